// File: rtl/golden_trace_checker_if.sv
// Bundle of the CPU-side and golden-ROM-side signals of the golden trace checker.
// The checker attaches through the slave modport. The CPU/ROM environment attaches through the master modport.
interface golden_trace_checker_if #(
    parameter int AW = 16
);
    logic [31:0]   pc;
    logic [31:0]   inst;
    logic [4:0]    dbg_raddr;
    logic [31:0]   dbg_rdata;
    logic [AW-1:0] gold_addr;
    logic [31:0]   gold_rdata;
    logic          chk_stall;
    logic          done;
    logic          pass;
    logic          fail;
    logic [19:0]   err_rec;
    logic [5:0]    err_field;
    logic [31:0]   err_expected;
    logic [31:0]   err_actual;
    logic [19:0]   rec_count;

    modport master (
        output pc, inst, dbg_rdata, gold_rdata,
        input  dbg_raddr, gold_addr, chk_stall, done, pass, fail,
               err_rec, err_field, err_expected, err_actual, rec_count
    );

    modport slave (
        input  pc, inst, dbg_rdata, gold_rdata,
        output dbg_raddr, gold_addr, chk_stall, done, pass, fail,
               err_rec, err_field, err_expected, err_actual, rec_count
    );
endinterface

// File: rtl/golden_trace_checker.sv
// Golden trace checker: on every new CPU pc it stalls the CPU and compares the live pc, instruction
// and all 32 registers against a 34-word golden record read from a synchronous ROM.
// The first mismatch halts the CPU. After NUM_RECORDS records have matched, the checker declares pass.
module golden_trace_checker #(
    parameter int          NUM_RECORDS = 1024,
    parameter int          AW          = 16,
    parameter logic [31:0] PC_SENTINEL = 32'h44436040
) (
    input  logic                  clk_in,
    input  logic                  reset,
    golden_trace_checker_if.slave bus
);

    typedef enum logic [1:0] {IDLE, CMP, PASS, FAIL} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [5:0]    cnt;
    logic [AW-1:0] base;
    logic [31:0]   pc_pre;
    logic [19:0]   rec_count_r;
    logic          done_r;
    logic          pass_r;
    logic          fail_r;
    logic [19:0]   err_rec_r;
    logic [5:0]    err_field_r;
    logic [31:0]   err_expected_r;
    logic [31:0]   err_actual_r;

    logic          trigger;
    logic          mismatch;
    logic          last_word;
    logic          last_rec;
    logic [31:0]   actual;
    logic [AW-1:0] gold_addr_c;
    logic [4:0]    dbg_raddr_c;
    logic          chk_stall_c;

    assign trigger   = (state == IDLE) && !reset && (bus.pc != pc_pre);
    assign mismatch  = (bus.gold_rdata != actual);
    assign last_word = (cnt == 6'd33);
    assign last_rec  = (({1'b0, rec_count_r} + 21'd1) == 21'(NUM_RECORDS));

    // Select the live value that corresponds to the golden word currently on the ROM bus
    always_comb begin
        actual = bus.dbg_rdata;
        if (cnt == 6'd0)
            actual = bus.pc;
        else if (cnt == 6'd1)
            actual = bus.inst;
    end

    // State register
    always_ff @(posedge clk_in) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state decision: a new pc starts a compare, and the end of a compare leads to pass, fail or idle
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (trigger) state_nxt = CMP;
            CMP: begin
                if (mismatch)
                    state_nxt = FAIL;
                else if (last_word)
                    state_nxt = last_rec ? PASS : IDLE;
            end
            default: state_nxt = state;
        endcase
    end

    // ROM address, regfile debug address and stall; the ROM is addressed one word ahead of the compare
    always_comb begin
        gold_addr_c = base;
        dbg_raddr_c = 5'd0;
        chk_stall_c = trigger;
        case (state)
            CMP: begin
                gold_addr_c = base + AW'(cnt) + AW'(1);
                dbg_raddr_c = (cnt >= 6'd2) ? 5'(cnt - 6'd2) : 5'd0;
                chk_stall_c = 1'b1;
            end
            FAIL:    chk_stall_c = 1'b1;
            default: ;
        endcase
    end

    // Word counter, record base, previous pc, verdict flags and first-mismatch capture
    always_ff @(posedge clk_in) begin
        if (reset) begin
            cnt            <= 6'd0;
            base           <= '0;
            pc_pre         <= PC_SENTINEL;
            rec_count_r    <= 20'd0;
            done_r         <= 1'b0;
            pass_r         <= 1'b0;
            fail_r         <= 1'b0;
            err_rec_r      <= 20'd0;
            err_field_r    <= 6'd0;
            err_expected_r <= 32'd0;
            err_actual_r   <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (trigger) begin
                        pc_pre <= bus.pc;
                        cnt    <= 6'd0;
                    end
                end
                CMP: begin
                    if (mismatch) begin
                        err_rec_r      <= rec_count_r;
                        err_field_r    <= cnt;
                        err_expected_r <= bus.gold_rdata;
                        err_actual_r   <= actual;
                        fail_r         <= 1'b1;
                        done_r         <= 1'b1;
                    end else if (last_word) begin
                        rec_count_r <= rec_count_r + 20'd1;
                        base        <= base + AW'(34);
                        if (last_rec) begin
                            pass_r <= 1'b1;
                            done_r <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 6'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.gold_addr    = gold_addr_c;
    assign bus.dbg_raddr    = dbg_raddr_c;
    assign bus.chk_stall    = chk_stall_c;
    assign bus.done         = done_r;
    assign bus.pass         = pass_r;
    assign bus.fail         = fail_r;
    assign bus.err_rec      = err_rec_r;
    assign bus.err_field    = err_field_r;
    assign bus.err_expected = err_expected_r;
    assign bus.err_actual   = err_actual_r;
    assign bus.rec_count    = rec_count_r;

endmodule

// File: tb/tb_golden_trace_checker.sv
// Testbench for golden_trace_checker: a small CPU model walks a program of states and obeys chk_stall.
// A synchronous ROM holds the golden trace. A reference model derives the expected record outcomes,
// and a monitor checks each record verdict as the DUT reports it.
module tb_golden_trace_checker;

    localparam int          NUM  = 3;
    localparam int          AW   = 16;
    localparam logic [31:0] SENT = 32'h44436040;

    typedef struct {
        bit          is_fail;
        int          rec;
        int          field;
        logic [31:0] exp_w;
        logic [31:0] act_w;
    } ev_t;

    logic        clk_in = 1'b0;
    logic        reset  = 1'b1;
    logic [31:0] prog_pc   [0:7];
    logic [31:0] prog_inst [0:7];
    logic [31:0] prog_regs [0:7][0:31];
    logic [31:0] rom       [0:255];
    logic [2:0]  idx = 3'd0;
    int          plen = 1;
    int          c_rec = -1;
    int          c_field = 0;
    logic [31:0] c_mask = 32'd0;
    ev_t         sbq[$];
    int          checks = 0;
    int          failures = 0;
    int          run_len = 0;
    logic [19:0] prev_rec = 20'd0;
    logic        prev_fail = 1'b0;

    golden_trace_checker_if #(.AW(AW)) bus();

    golden_trace_checker #(
        .NUM_RECORDS(NUM),
        .AW(AW),
        .PC_SENTINEL(SENT)
    ) dut (
        .clk_in(clk_in),
        .reset(reset),
        .bus(bus)
    );

    assign bus.pc        = prog_pc[idx];
    assign bus.inst      = prog_inst[idx];
    assign bus.dbg_rdata = prog_regs[idx][bus.dbg_raddr];

    // Clock generation
    initial forever #5 clk_in = ~clk_in;

    // Synchronous golden ROM: data appears one cycle after the address
    always @(posedge clk_in) bus.gold_rdata <= rom[bus.gold_addr[7:0]];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] live_word(input int i, input int w);
        if (w == 0) return prog_pc[i];
        if (w == 1) return prog_inst[i];
        return prog_regs[i][w-2];
    endfunction

    task automatic make_prog(input int len);
        plen = len;
        for (int i = 0; i < len; i++) begin
            prog_pc[i]      = 32'h00400010 + 32'(4 * i);
            prog_inst[i]    = $urandom;
            prog_regs[i][0] = 32'd0;
            for (int r = 1; r < 32; r++) prog_regs[i][r] = $urandom;
        end
        c_rec   = -1;
        c_field = 0;
        c_mask  = 32'd0;
    endtask

    // Reference model: records are the live states at each pc change; the first differing word of a record fails
    task automatic build_model();
        int          trig[8];
        int          nrec = 0;
        logic [31:0] prev = SENT;
        bit          stop = 0;
        ev_t         e;
        int          bad;
        for (int a = 0; a < 256; a++) rom[a] = 32'd0;
        for (int i = 0; i < plen; i++) begin
            if (prog_pc[i] != prev) begin
                trig[nrec] = i;
                nrec++;
                prev = prog_pc[i];
            end
        end
        for (int r = 0; r < nrec && r < NUM; r++)
            for (int w = 0; w < 34; w++)
                rom[34*r+w] = live_word(trig[r], w) ^ ((r == c_rec && w == c_field) ? c_mask : 32'd0);
        for (int r = 0; r < nrec && r < NUM && !stop; r++) begin
            bad = -1;
            for (int w = 0; w < 34; w++)
                if (bad < 0 && rom[34*r+w] != live_word(trig[r], w)) bad = w;
            if (bad >= 0) begin
                e.is_fail = 1; e.rec = r; e.field = bad;
                e.exp_w = rom[34*r+bad]; e.act_w = live_word(trig[r], bad);
                sbq.push_back(e);
                stop = 1;
            end else begin
                e.is_fail = 0; e.rec = r + 1; e.field = 0; e.exp_w = 0; e.act_w = 0;
                sbq.push_back(e);
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk_in);
        #1;
        sbq.delete();
        idx = 3'd0;
        build_model();
        reset = 1'b0;
    endtask

    // One CPU cycle: the CPU moves to its next state only if it was not stalled in this cycle
    task automatic step_cpu();
        logic s;
        @(negedge clk_in);
        s = bus.chk_stall;
        @(posedge clk_in);
        #1;
        if (!s && int'(idx) < plen - 1) idx = idx + 3'd1;
    endtask

    task automatic applyStimulus(input int cycles);
        repeat (cycles) step_cpu();
    endtask

    task automatic wait_drain(input int budget);
        for (int k = 0; k < budget && sbq.size() != 0; k++) step_cpu();
        checkOutput("sb_drain", 32'(sbq.size()), 32'd0);
    endtask

    task automatic check_reset_state();
        checkOutput("rst_done", 32'(bus.done), 32'd0);
        checkOutput("rst_pass", 32'(bus.pass), 32'd0);
        checkOutput("rst_fail", 32'(bus.fail), 32'd0);
        checkOutput("rst_stall", 32'(bus.chk_stall), 32'd0);
        checkOutput("rst_rec_count", 32'(bus.rec_count), 32'd0);
        checkOutput("rst_gold_addr", 32'(bus.gold_addr), 32'd0);
        checkOutput("rst_dbg_raddr", 32'(bus.dbg_raddr), 32'd0);
        checkOutput("rst_err_rec", 32'(bus.err_rec), 32'd0);
        checkOutput("rst_err_field", 32'(bus.err_field), 32'd0);
        checkOutput("rst_err_expected", bus.err_expected, 32'd0);
        checkOutput("rst_err_actual", bus.err_actual, 32'd0);
    endtask

    // Monitor: checks stall run lengths and matches each record verdict against the scoreboard
    initial forever begin
        ev_t e;
        @(negedge clk_in);
        if (reset) begin
            run_len   = 0;
            prev_rec  = bus.rec_count;
            prev_fail = bus.fail;
        end else begin
            if (bus.chk_stall) begin
                run_len++;
            end else begin
                if (run_len > 0) checkOutput("stall_len", 32'(run_len), 32'd35);
                run_len = 0;
            end
            if ((bus.fail && !prev_fail) || bus.rec_count != prev_rec) begin
                if (sbq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_event: rec_count %0d fail %0b, nothing expected",
                             bus.rec_count, bus.fail);
                end else begin
                    e = sbq.pop_front();
                    checkOutput("ev_fail", 32'(bus.fail), 32'(e.is_fail));
                    checkOutput("ev_pass", 32'(bus.pass), 32'(!e.is_fail && e.rec == NUM));
                    checkOutput("ev_done", 32'(bus.done), 32'(e.is_fail || e.rec == NUM));
                    checkOutput("ev_rec_count", 32'(bus.rec_count), 32'(e.rec));
                    if (e.is_fail) begin
                        checkOutput("err_rec", 32'(bus.err_rec), 32'(e.rec));
                        checkOutput("err_field", 32'(bus.err_field), 32'(e.field));
                        checkOutput("err_expected", bus.err_expected, e.exp_w);
                        checkOutput("err_actual", bus.err_actual, e.act_w);
                        checkOutput("fail_stall", 32'(bus.chk_stall), 32'd1);
                        checkOutput("fail_latency", 32'(run_len), 32'(e.field + 3));
                    end else begin
                        checkOutput("ev_gold_addr", 32'(bus.gold_addr), 32'(34 * e.rec));
                    end
                end
            end
            prev_rec  = bus.rec_count;
            prev_fail = bus.fail;
        end
    end

    // Directed scenarios followed by randomized corruption runs
    initial begin
        bit found;
        $display("[TB] start");

        make_prog(3);
        reset = 1'b1;
        repeat (2) @(posedge clk_in);
        #1;
        check_reset_state();

        // Three matching records then continued execution after pass
        make_prog(6);
        do_reset();
        wait_drain(400);
        applyStimulus(40);
        checkOutput("s1_pass", 32'(bus.pass), 32'd1);
        checkOutput("s1_rec_count", 32'(bus.rec_count), 32'd3);
        checkOutput("s1_stall", 32'(bus.chk_stall), 32'd0);
        checkOutput("s1_gold_addr", 32'(bus.gold_addr), 32'd102);
        checkOutput("s1_cpu_ran", 32'(idx), 32'd5);

        // Regfile5 mismatch in record 1
        make_prog(4);
        prog_regs[1][5] = 32'h6;
        c_rec = 1; c_field = 7; c_mask = 32'h6 ^ 32'h5;
        do_reset();
        wait_drain(300);
        applyStimulus(20);
        checkOutput("s2_stall_held", 32'(bus.chk_stall), 32'd1);
        checkOutput("s2_err_expected", bus.err_expected, 32'h5);
        checkOutput("s2_err_actual", bus.err_actual, 32'h6);
        checkOutput("s2_err_field", 32'(bus.err_field), 32'd7);
        checkOutput("s2_cpu_halted", 32'(idx), 32'd1);

        // pc mismatch in record 0
        make_prog(3);
        prog_pc[0] = 32'h00400004;
        c_rec = 0; c_field = 0; c_mask = 32'h00400004 ^ 32'h00400000;
        do_reset();
        wait_drain(100);
        checkOutput("s3_err_expected", bus.err_expected, 32'h00400000);

        // Reset in the middle of record 2
        make_prog(3);
        do_reset();
        found = 0;
        for (int k = 0; k < 300 && !found; k++) begin
            step_cpu();
            #1;
            if (bus.rec_count == 20'd2 && bus.chk_stall) found = 1;
        end
        checkOutput("s4_rec2_reached", 32'(found), 32'd1);
        repeat (11) step_cpu();
        reset = 1'b1;
        @(posedge clk_in);
        #1;
        check_reset_state();
        do_reset();
        #1;
        checkOutput("s4_restart_addr", 32'(bus.gold_addr), 32'd0);
        checkOutput("s4_restart_trigger", 32'(bus.chk_stall), 32'd1);
        wait_drain(400);
        checkOutput("s4_pass", 32'(bus.pass), 32'd1);

        // Self-loop: pc never changes after the first record
        make_prog(4);
        for (int i = 1; i < 4; i++) prog_pc[i] = prog_pc[0];
        do_reset();
        wait_drain(200);
        applyStimulus(20);
        checkOutput("s5_rec_count", 32'(bus.rec_count), 32'd1);
        checkOutput("s5_stall", 32'(bus.chk_stall), 32'd0);
        checkOutput("s5_done", 32'(bus.done), 32'd0);
        checkOutput("s5_cpu_ran", 32'(idx), 32'd3);

        // pc revisiting an older value triggers again
        make_prog(3);
        prog_pc[2] = prog_pc[0];
        do_reset();
        wait_drain(300);
        checkOutput("s6_rec_count", 32'(bus.rec_count), 32'd3);

        // Randomized single-bit corruptions (record 3 is beyond NUM and means no corruption)
        for (int t = 0; t < 6; t++) begin
            make_prog(3 + int'($urandom_range(0, 3)));
            c_rec   = int'($urandom_range(0, 3));
            c_field = int'($urandom_range(0, 33));
            c_mask  = 32'd1 << $urandom_range(0, 31);
            do_reset();
            wait_drain(400);
            applyStimulus(10);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
